// File: rtl/mult_port_pkg.sv
// Shared types and helpers for the pin-side multiplier port.
// Holds the handshake state encoding and byte-index sizing.
package mult_port_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    REQ    = 2'd1,
    REL    = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  localparam int BYTE_W = 8;

  // Width of a byte index over nb bytes; never below one bit.
  function automatic int idx_width(input int nb);
    return (nb <= 2) ? 1 : $clog2(nb);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Clears to 0 on reset; output is the last flop of the chain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/mult_pin_port.sv
// Pin-side responder: collects operand bytes, runs a four-phase req/ack
// handshake with the multiplier core, then streams the product out bytewise.
module mult_pin_port
  import mult_port_pkg::*;
#(
  parameter int OP_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [7:0]        din,
  input  logic              wr_stb,
  input  logic              rd_stb,
  output logic [7:0]        dout,
  output logic              busy,
  output logic              done,
  output logic              mul_req,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_ack,
  input  logic [2*OP_W-1:0] mul_p
);

  localparam int NB = 2 * OP_W / BYTE_W;
  localparam int IW = idx_width(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [2:0] async_in;
  logic [2:0] synced;
  logic       wr_sync, rd_sync, ack_sync;

  assign async_in = {mul_ack, rd_stb, wr_stb};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (async_in[gi]),
        .q   (synced[gi])
      );
    end
  endgenerate

  assign wr_sync  = synced[0];
  assign rd_sync  = synced[1];
  assign ack_sync = synced[2];

  // Edge history runs regardless of ena so a strobe held across ena=0 never
  // looks like a fresh edge once the design is reselected.
  logic wr_prev_reg, rd_prev_reg;
  logic wr_edge, rd_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev_reg <= 1'b0;
      rd_prev_reg <= 1'b0;
    end else begin
      wr_prev_reg <= wr_sync;
      rd_prev_reg <= rd_sync;
    end
  end

  assign wr_edge = ena & wr_sync & ~wr_prev_reg;
  assign rd_edge = ena & rd_sync & ~rd_prev_reg;

  state_t            state_reg, state_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [2*OP_W-1:0] ops_reg, ops_next;
  logic [2*OP_W-1:0] prod_reg, prod_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
      idx_reg   <= '0;
      ops_reg   <= '0;
      prod_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ops_reg   <= ops_next;
      prod_reg  <= prod_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ops_next   = ops_reg;
    prod_next  = prod_reg;
    case (state_reg)
      LOAD: begin
        if (wr_edge) begin
          ops_next[BYTE_W*idx_reg +: BYTE_W] = din;
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = REQ;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      REQ: begin
        // mul_p is bundled with ack, so it is settled once ack is synced.
        if (ack_sync) begin
          prod_next  = mul_p;
          state_next = REL;
        end
      end
      REL: begin
        if (!ack_sync) begin
          idx_next   = '0;
          state_next = UNLOAD;
        end
      end
      UNLOAD: begin
        if (rd_edge) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = LOAD;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      default: begin
        state_next = LOAD;
        idx_next   = '0;
      end
    endcase
  end

  // Decoded straight from state so an async reset drops mul_req at once.
  assign mul_req = (state_reg == REQ);
  assign busy    = (state_reg == REQ) || (state_reg == REL);
  assign done    = (state_reg == UNLOAD);
  assign dout    = (state_reg == UNLOAD) ? prod_reg[BYTE_W*idx_reg +: BYTE_W] : '0;
  assign mul_a   = ops_reg[OP_W-1:0];
  assign mul_b   = ops_reg[2*OP_W-1:OP_W];

endmodule

// File: tb/tb_mult_pin_port.sv
// Self-checking bench for mult_pin_port: pin protocol driver, behavioural
// core model and arithmetic reference for the expected product bytes.
module tb_mult_pin_port;

  localparam int OP_W = 16;
  localparam int SYNC = 2;
  localparam int NB   = 2 * OP_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ena = 1'b1;
  logic [7:0]        din = '0;
  logic              wr_stb = 1'b0;
  logic              rd_stb = 1'b0;
  logic [7:0]        dout;
  logic              busy, done, mul_req;
  logic [OP_W-1:0]   mul_a, mul_b;
  logic              mul_ack;
  logic [2*OP_W-1:0] mul_p;

  int n_checks = 0;
  int n_fail   = 0;
  int req_count = 0;
  int ack_delay = 5;

  always #5 clk = ~clk;

  mult_pin_port #(.OP_W(OP_W), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .din     (din),
    .wr_stb  (wr_stb),
    .rd_stb  (rd_stb),
    .dout    (dout),
    .busy    (busy),
    .done    (done),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
    .mul_p   (mul_p)
  );

  // Behavioural core: answers each request after ack_delay clocks.
  initial begin
    mul_ack = 1'b0;
    mul_p   = '0;
    forever begin
      @(posedge clk);
      if (mul_req === 1'b1 && !mul_ack) begin
        req_count++;
        repeat (ack_delay) @(posedge clk);
        #1;
        if (mul_req === 1'b1) begin
          mul_p = 32'(mul_a) * 32'(mul_b);
          #1 mul_ack = 1'b1;
          for (int k = 0; k < 200 && mul_req === 1'b1; k++) @(posedge clk);
          #1 mul_ack = 1'b0;
        end
      end
    end
  end

  task automatic pulse(input bit w, input bit r, input logic [7:0] d);
    @(posedge clk);
    #1;
    din    = d;
    wr_stb = w;
    rd_stb = r;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    wr_stb = 1'b0;
    rd_stb = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Full transaction; extra=1 adds illegal wr edges during busy and unload.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input bit extra);
    logic [31:0] exp_p;
    logic [31:0] ops;
    logic [7:0]  exp_byte;
    int          cnt0;
    bit          ok;
    bit          saw_busy;
    exp_p = 32'(a) * 32'(b);
    ops   = {b, a};
    cnt0  = req_count;
    for (int i = 0; i < NB; i++) begin
      exp_byte = 8'((ops >> (8 * i)) & 32'hFF);
      pulse(1'b1, 1'b0, exp_byte);
    end
    saw_busy = (busy === 1'b1);
    if (extra) begin
      pulse(1'b1, 1'b0, 8'hA5);
      pulse(1'b1, 1'b0, 8'h5A);
    end
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL txn_done_timeout: done=%b required 1 (a=%h b=%h)", done, a, b);
    end
    n_checks++;
    if (!saw_busy) begin
      n_fail++;
      $display("FAIL txn_busy: busy not high after last write, required 1 (a=%h b=%h)", a, b);
    end
    if (extra) pulse(1'b1, 1'b0, 8'hC3);
    n_checks++;
    if (mul_a !== a || mul_b !== b) begin
      n_fail++;
      $display("FAIL txn_operands: mul_a=%h mul_b=%h required %h %h", mul_a, mul_b, a, b);
    end
    n_checks++;
    if (req_count !== cnt0 + 1) begin
      n_fail++;
      $display("FAIL txn_req_count: %0d requests, required 1", req_count - cnt0);
    end
    for (int i = 0; i < NB; i++) begin
      exp_byte = 8'((exp_p >> (8 * i)) & 32'hFF);
      n_checks++;
      if (dout !== exp_byte || done !== 1'b1) begin
        n_fail++;
        $display("FAIL txn_byte%0d: dout=%h done=%b required %h 1", i, dout, done, exp_byte);
      end
      pulse(extra && i == 0, 1'b1, 8'h77);
    end
    n_checks++;
    if (done !== 1'b0 || dout !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL txn_end: done=%b dout=%h busy=%b required 0 00 0", done, dout, busy);
    end
    $display("txn a=%h b=%h product=%h extra=%0d", a, b, exp_p, extra);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || mul_req !== 1'b0 ||
        mul_a !== 16'h0 || mul_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: dout=%h busy=%b done=%b req=%b a=%h b=%h required all 0",
               dout, busy, done, mul_req, mul_a, mul_b);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    ack_delay = 5;
    do_txn(16'h1234, 16'h00FF, 1'b0);
  endtask

  task automatic test_max_operands();
    do_txn(16'hFFFF, 16'hFFFF, 1'b0);
  endtask

  task automatic test_ena_low();
    ena = 1'b0;
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 8'(8'h90 + i));
    ena = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mul_a !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL ena_low_hold: busy=%b done=%b mul_a=%h required 0 0 ffff", busy, done, mul_a);
    end
    $display("ena low writes dropped");
    do_txn(16'h1234, 16'h00FF, 1'b0);
  endtask

  task automatic test_ignored_edges();
    pulse(1'b0, 1'b1, 8'h00);
    n_checks++;
    if (done !== 1'b0 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL rd_in_load: done=%b dout=%h required 0 00", done, dout);
    end
    ack_delay = 25;
    do_txn(16'hBEEF, 16'h0102, 1'b1);
    ack_delay = 5;
  endtask

  task automatic test_reset_mid_handshake();
    bit ok;
    for (int i = 0; i < NB; i++) pulse(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mul_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midrst_req_rise: mul_req=%b required 1", mul_req);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mul_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_drop: req=%b busy=%b done=%b required 0 0 0", mul_req, busy, done);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("reset during handshake checked");
    do_txn(16'h0F0F, 16'hA0A0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int t = 0; t < 6; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      ack_delay = $urandom_range(1, 12);
      do_txn(a, b, 1'b0);
    end
    ack_delay = 5;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_ena_low();
    test_ignored_edges();
    test_reset_mid_handshake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
